decoder_scan_nto2n: RTL and testbench



---
 rtl/decoder_scan_nto2n_pkg.sv | 26 ++
 rtl/decoder_scan_nto2n_scan_timer.sv | 36 +++
 rtl/decoder_scan_nto2n.sv | 85 ++++++++
 tb/tb_decoder_scan_nto2n.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_nto2n_pkg.sv
// Shared types, constants and the one-hot helper for the scanning decoder.
package decoder_pkg;

  // Widest supported select; the one-hot helper works at this width and
  // callers truncate to their own line count.
  localparam int MAX_N     = 6;
  localparam int MAX_LINES = 1 << MAX_N;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } dec_state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // One-hot pattern with bit `idx` set, at the maximum line count.
  function automatic logic [MAX_LINES-1:0] onehot(input logic [MAX_N-1:0] idx);
    logic [MAX_LINES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_scan_nto2n_scan_timer.sv
// Dwell counter for the scan mode: counts up while running and reports
// `tick` once the count has reached the (live) dwell value.
module scan_timer
  #(
    parameter int DWELL_W = 8
  )
  (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
  );

  logic [DWELL_W-1:0] count_reg;

  // Compared combinationally so a lowered dwell takes effect on the next edge.
  assign tick = (count_reg >= dwell);

  // Count up while running; restart after each tick or on an explicit clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (run) begin
      if (tick) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + DWELL_W'(1);
      end
    end
  end

endmodule

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-hot decoder with enable, direct decode and an
// autonomous scan mode that walks the active line with a programmable dwell.
module decoder_scan_nto2n
  import decoder_pkg::*;
  #(
    parameter int N       = 2,
    parameter int DWELL_W = 8
  )
  (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [N-1:0]       in,
    input  logic [DWELL_W-1:0] dwell,
    output logic [(1<<N)-1:0]  out,
    output logic [N-1:0]       idx,
    output logic               wrap
  );

  localparam int LINES = 1 << N;

  dec_state_t       state_reg;
  logic [N-1:0]     idx_reg;
  logic [LINES-1:0] out_reg;
  logic             wrap_reg;

  logic             scan_hold;
  logic             timer_tick;
  logic [N-1:0]     idx_inc;
  logic [LINES-1:0] in_hot;
  logic [LINES-1:0] inc_hot;

  // Scan only continues when already scanning; any other case restarts the dwell.
  assign scan_hold = en && (mode == MODE_SCAN) && (state_reg == SCAN);
  assign idx_inc   = idx_reg + N'(1);
  assign in_hot    = LINES'(onehot(MAX_N'(in)));
  assign inc_hot   = LINES'(onehot(MAX_N'(idx_inc)));

  scan_timer #(
    .DWELL_W (DWELL_W)
  ) u_scan_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!scan_hold),
    .run   (scan_hold),
    .dwell (dwell),
    .tick  (timer_tick)
  );

  // Mode FSM with registered line outputs; enable has priority, then mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      out_reg   <= '0;
      wrap_reg  <= 1'b0;
    end else if (!en) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      wrap_reg  <= 1'b0;
    end else if (mode == MODE_DIRECT) begin
      state_reg <= DIRECT;
      idx_reg   <= in;
      out_reg   <= in_hot;
      wrap_reg  <= 1'b0;
    end else if (state_reg != SCAN) begin
      state_reg <= SCAN;
      idx_reg   <= in;
      out_reg   <= in_hot;
      wrap_reg  <= 1'b0;
    end else if (timer_tick) begin
      idx_reg   <= idx_inc;
      out_reg   <= inc_hot;
      wrap_reg  <= (idx_inc == '0);
    end else begin
      wrap_reg  <= 1'b0;
    end
  end

  assign out  = out_reg;
  assign idx  = idx_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Self-checking bench: four decoder instances (N = 1, 2, 3, 6) share one
// stimulus stream and are compared each cycle against a behavioural model;
// directed sequences additionally check literal expected patterns.
module tb_decoder_scan_nto2n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [5:0] in_bus;
  logic [7:0] dwell;

  logic [1:0]  out_n1;
  logic [3:0]  out_n2;
  logic [7:0]  out_n3;
  logic [63:0] out_n6;
  logic [0:0]  idx_n1;
  logic [1:0]  idx_n2;
  logic [2:0]  idx_n3;
  logic [5:0]  idx_n6;
  logic        wrap_n1, wrap_n2, wrap_n3, wrap_n6;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: 0 idle, 1 direct, 2 scan.
  int m_state [4];
  int m_idx   [4];
  int m_cnt   [4];
  int m_wrap  [4];

  decoder_scan_nto2n #(.N(1), .DWELL_W(8)) u_n1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in_bus[0:0]),
    .dwell(dwell), .out(out_n1), .idx(idx_n1), .wrap(wrap_n1));
  decoder_scan_nto2n #(.N(2), .DWELL_W(8)) u_n2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in_bus[1:0]),
    .dwell(dwell), .out(out_n2), .idx(idx_n2), .wrap(wrap_n2));
  decoder_scan_nto2n #(.N(3), .DWELL_W(8)) u_n3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in_bus[2:0]),
    .dwell(dwell), .out(out_n3), .idx(idx_n3), .wrap(wrap_n3));
  decoder_scan_nto2n #(.N(6), .DWELL_W(8)) u_n6 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in(in_bus[5:0]),
    .dwell(dwell), .out(out_n6), .idx(idx_n6), .wrap(wrap_n6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 6;
    endcase
  endfunction

  function automatic logic [63:0] obs_out(input int k);
    case (k)
      0: return 64'(out_n1);
      1: return 64'(out_n2);
      2: return 64'(out_n3);
      default: return out_n6;
    endcase
  endfunction

  function automatic logic [63:0] obs_idx(input int k);
    case (k)
      0: return 64'(idx_n1);
      1: return 64'(idx_n2);
      2: return 64'(idx_n3);
      default: return 64'(idx_n6);
    endcase
  endfunction

  function automatic logic [63:0] obs_wrap(input int k);
    case (k)
      0: return 64'(wrap_n1);
      1: return 64'(wrap_n2);
      2: return 64'(wrap_n3);
      default: return 64'(wrap_n6);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_state[k] = 0;
      m_idx[k]   = 0;
      m_cnt[k]   = 0;
      m_wrap[k]  = 0;
    end
  endtask

  // One rising edge of the behavioural model, using the current inputs.
  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      int lines;
      int sel;
      lines = 1 << n_of(k);
      sel   = int'(in_bus) % lines;
      m_wrap[k] = 0;
      if (!en) begin
        m_state[k] = 0;
        m_cnt[k]   = 0;
      end else if (!mode) begin
        m_state[k] = 1;
        m_idx[k]   = sel;
        m_cnt[k]   = 0;
      end else if (m_state[k] != 2) begin
        m_state[k] = 2;
        m_idx[k]   = sel;
        m_cnt[k]   = 0;
      end else if (m_cnt[k] < int'(dwell)) begin
        m_cnt[k] = m_cnt[k] + 1;
      end else begin
        m_cnt[k] = 0;
        m_idx[k] = (m_idx[k] + 1) % lines;
        m_wrap[k] = (m_idx[k] == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      logic [63:0] exp_out;
      exp_out = (m_state[k] == 0) ? 64'd0 : (64'd1 << m_idx[k]);
      check_value($sformatf("out N=%0d", n_of(k)), obs_out(k), exp_out);
      check_value($sformatf("idx N=%0d", n_of(k)), obs_idx(k), 64'(m_idx[k]));
      check_value($sformatf("wrap N=%0d", n_of(k)), obs_wrap(k), 64'(m_wrap[k]));
      check_value($sformatf("onehot N=%0d", n_of(k)),
                  64'($countones(obs_out(k)) <= 1), 64'd1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int wraps;
    int first_wrap;
    logic [3:0] scan_seq [5];
    scan_seq[0] = 4'b0100; scan_seq[1] = 4'b1000; scan_seq[2] = 4'b0001;
    scan_seq[3] = 4'b0010; scan_seq[4] = 4'b0100;

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_bus = '0; dwell = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Disabled: output stays dark whatever the index.
    for (int i = 0; i < 4; i++) begin
      in_bus = 6'(i);
      tick();
      check_value("disabled out", 64'(out_n2), 64'd0);
      $display("disable in=%0d out=%b", i, out_n2);
    end

    // Direct decode, one cycle latency.
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_bus = 6'(i);
      tick();
      check_value("direct out", 64'(out_n2), 64'd1 << i);
      $display("direct in=%0d out=%b", i, out_n2);
    end

    // Scan with dwell 0 from index 2.
    mode = 1'b1; in_bus = 6'd2; dwell = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("scan0 out", 64'(out_n2), 64'(scan_seq[i]));
      check_value("scan0 wrap", 64'(wrap_n2), 64'(scan_seq[i] == 4'b0001));
      $display("scan0 step=%0d out=%b wrap=%b", i, out_n2, wrap_n2);
    end

    // Disable mid-scan, then restart from in=1.
    en = 1'b0;
    tick();
    check_value("scan disable", 64'(out_n2), 64'd0);
    en = 1'b1; in_bus = 6'd1;
    tick();
    check_value("scan reentry", 64'(out_n2), 64'b0010);
    tick();
    check_value("scan reentry next", 64'(out_n2), 64'b0100);
    $display("reentry out=%b", out_n2);

    // Switch to direct mid-scan.
    mode = 1'b0; in_bus = 6'd3;
    tick();
    check_value("scan to direct", 64'(out_n2), 64'b1000);
    $display("to direct out=%b", out_n2);

    // Asynchronous reset in mid-cycle while scanning.
    mode = 1'b1; in_bus = 6'd1;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_value("async rst out", 64'(out_n2), 64'd0);
    check_value("async rst idx", 64'(idx_n2), 64'd0);
    check_value("async rst wrap", 64'(wrap_n2), 64'd0);
    model_reset();
    check_all();
    $display("async reset out=%b idx=%0d", out_n2, idx_n2);
    @(negedge clk);
    rst_n = 1'b1;

    // Dwell 3 on N=3, then lower dwell to 1 while count is 2.
    dwell = 8'd3; in_bus = 6'd0; mode = 1'b1;
    tick();
    tick();
    tick();
    check_value("dwell hold", 64'(out_n3), 64'b1);
    dwell = 8'd1;
    tick();
    check_value("dwell lowered", 64'(out_n3), 64'b10);
    $display("dwell lowered out=%b", out_n3);

    // Wrap period for N=3, dwell 3: one wrap every 32 cycles.
    dwell = 8'd3; mode = 1'b0;
    tick();
    mode = 1'b1;
    tick();
    wraps = 0; first_wrap = -1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (wrap_n3) begin
        wraps++;
        if (first_wrap < 0) first_wrap = i;
      end
    end
    check_value("wrap count", 64'(wraps), 64'd2);
    check_value("wrap first", 64'(first_wrap), 64'd32);
    $display("wrap period wraps=%0d first=%0d", wraps, first_wrap);

    // Maximum dwell holds each line 256 cycles (watch N=1).
    dwell = 8'd255; mode = 1'b0;
    tick();
    mode = 1'b1;
    tick();
    for (int i = 1; i <= 256; i++) begin
      tick();
      if (i == 255) check_value("maxdwell hold", 64'(out_n1), 64'b01);
      if (i == 256) check_value("maxdwell adv", 64'(out_n1), 64'b10);
    end
    $display("max dwell out=%b", out_n1);

    // Randomised traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) == 0) en = 1'b0;
      else en = 1'b1;
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      in_bus = 6'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) dwell = 8'($urandom_range(0, 3));
        else if (r < 9) dwell = 8'($urandom_range(0, 15));
        else dwell = 8'd255;
      end
      tick();
      if ($urandom_range(0, 199) == 0) begin
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
